// File: rtl/bcd3_signed_addsub_seq_pkg.sv
// Shared constants and helpers for the sequential 3-digit signed BCD adder/subtractor.
package bcd3_signed_addsub_seq_pkg;

  localparam int         NDIG     = 3;
  localparam logic [3:0] BCD_NINE = 4'd9;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADD0  = 4'd1;
  localparam logic [3:0] S_ADD1  = 4'd2;
  localparam logic [3:0] S_ADD2  = 4'd3;
  localparam logic [3:0] S_CHK   = 4'd4;
  localparam logic [3:0] S_COMP0 = 4'd5;
  localparam logic [3:0] S_COMP1 = 4'd6;
  localparam logic [3:0] S_COMP2 = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  function automatic logic [3:0] digit_of(input logic [11:0] v, input logic [1:0] k);
    case (k)
      2'd0:    digit_of = v[3:0];
      2'd1:    digit_of = v[7:4];
      default: digit_of = v[11:8];
    endcase
  endfunction

  function automatic logic has_bad_digit(input logic [11:0] v);
    has_bad_digit = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (v[4*k +: 4] > BCD_NINE) has_bad_digit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/bcd3_signed_addsub_seq_bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal (+6) correction.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] bin;
  logic [3:0] adj;

  assign bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign cout = bin[4] | (bin[3:0] > 4'd9);
  assign adj  = bin[3:0] + 4'd6;
  assign sum  = cout ? adj : bin[3:0];

endmodule

// File: rtl/bcd3_signed_addsub_seq.sv
// Sequential signed-magnitude 3-digit BCD add/subtract: one digit per cycle through a
// shared digit adder, with a 10's-complement pass when a subtraction goes negative.
module bcd3_signed_addsub_seq
  import bcd3_signed_addsub_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [11:0] a_bcd,
  input  logic [11:0] b_bcd,
  output logic        busy,
  output logic        done,
  output logic [11:0] r_bcd,
  output logic        sign_r,
  output logic        ovf,
  output logic        invalid
);

  logic [3:0]  state;
  logic [11:0] a_reg, b_reg, part, part_nxt;
  logic        sign_a_reg, eff_sub, carry, bad_in;
  logic [1:0]  dig;
  logic        in_add, in_comp;
  logic [3:0]  add_a, add_b, add_sum, b_dig;
  logic        add_cin, add_cout;

  bcd_digit_adder u_digit (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Select which digit the shared adder works on and what it is fed.
  always_comb begin
    dig     = 2'd0;
    in_add  = 1'b0;
    in_comp = 1'b0;
    case (state)
      S_ADD0:  begin dig = 2'd0; in_add  = 1'b1; end
      S_ADD1:  begin dig = 2'd1; in_add  = 1'b1; end
      S_ADD2:  begin dig = 2'd2; in_add  = 1'b1; end
      S_COMP0: begin dig = 2'd0; in_comp = 1'b1; end
      S_COMP1: begin dig = 2'd1; in_comp = 1'b1; end
      S_COMP2: begin dig = 2'd2; in_comp = 1'b1; end
      default: ;
    endcase
    b_dig   = digit_of(b_reg, dig);
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (in_add) begin
      add_a   = digit_of(a_reg, dig);
      add_b   = eff_sub ? (BCD_NINE - b_dig) : b_dig;
      add_cin = (dig == 2'd0) ? eff_sub : carry;
    end else if (in_comp) begin
      add_a   = BCD_NINE - digit_of(part, dig);
      add_cin = (dig == 2'd0) ? 1'b1 : carry;
    end
    part_nxt = part;
    case (dig)
      2'd0:    part_nxt[3:0]  = add_sum;
      2'd1:    part_nxt[7:4]  = add_sum;
      default: part_nxt[11:8] = add_sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      part       <= '0;
      sign_a_reg <= 1'b0;
      eff_sub    <= 1'b0;
      carry      <= 1'b0;
      bad_in     <= 1'b0;
      r_bcd      <= '0;
      sign_r     <= 1'b0;
      ovf        <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg      <= a_bcd;
            b_reg      <= b_bcd;
            sign_a_reg <= sign_a;
            eff_sub    <= op ^ sign_a ^ sign_b;
            bad_in     <= has_bad_digit(a_bcd) | has_bad_digit(b_bcd);
            carry      <= 1'b0;
            part       <= '0;
            state      <= S_ADD0;
          end
        end
        S_ADD0, S_ADD1, S_ADD2, S_COMP0, S_COMP1: begin
          part  <= part_nxt;
          carry <= add_cout;
          state <= state + 4'd1;
        end
        S_CHK: begin
          // A subtraction without end-around carry means |B| > |A|: recomplement.
          if (eff_sub && !carry) begin
            state <= S_COMP0;
          end else begin
            r_bcd   <= part;
            ovf     <= carry & ~eff_sub;
            sign_r  <= sign_a_reg & (part != 12'd0);
            invalid <= bad_in;
            state   <= S_DONE;
          end
        end
        S_COMP2: begin
          part    <= part_nxt;
          carry   <= add_cout;
          r_bcd   <= part_nxt;
          ovf     <= 1'b0;
          sign_r  <= ~sign_a_reg & (part_nxt != 12'd0);
          invalid <= bad_in;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_bcd3_signed_addsub_seq.sv
// Directed self-checking bench for bcd3_signed_addsub_seq.
module tb_bcd3_signed_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        sign_a = 1'b0;
  logic        sign_b = 1'b0;
  logic [11:0] a_bcd = '0;
  logic [11:0] b_bcd = '0;
  logic        busy, done, sign_r, ovf, invalid;
  logic [11:0] r_bcd;

  int checks = 0;
  int failures = 0;

  bcd3_signed_addsub_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .sign_a  (sign_a),
    .sign_b  (sign_b),
    .a_bcd   (a_bcd),
    .b_bcd   (b_bcd),
    .busy    (busy),
    .done    (done),
    .r_bcd   (r_bcd),
    .sign_r  (sign_r),
    .ovf     (ovf),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one transaction; latency counts cycles after the start-sampling edge (1 = first busy cycle).
  task automatic do_op(input logic o, input logic sa, input logic [11:0] a,
                       input logic sb, input logic [11:0] b,
                       output int lat, output logic [11:0] r, output logic s,
                       output logic v, output logic iv, output logic busy1,
                       output logic done_after);
    op = o; sign_a = sa; a_bcd = a; sign_b = sb; b_bcd = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    lat = 1;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    r = r_bcd; s = sign_r; v = ovf; iv = invalid;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, r_bcd, sign_r, ovf, invalid} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0", {busy, done, r_bcd, sign_r, ovf, invalid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; logic [11:0] r; logic s, v, iv, b1, d2;
    do_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, lat, r, s, v, iv, b1, d2);
    checks++; if (lat !== 5) begin failures++; $display("FAIL add_latency got %0d want 5", lat); end
    checks++; if ({r, s, v, iv} !== {12'h579, 3'b000}) begin failures++; $display("FAIL add_579 got r=%h s=%b o=%b i=%b want r=579 s=0 o=0 i=0", r, s, v, iv); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL add_busy got %b want 1", b1); end
    checks++; if (d2 !== 1'b0) begin failures++; $display("FAIL add_done_pulse got %b want 0", d2); end
    do_op(1'b0, 1'b0, 12'h999, 1'b0, 12'h001, lat, r, s, v, iv, b1, d2);
    checks++; if ({r, s, v, iv} !== {12'h000, 3'b010}) begin failures++; $display("FAIL add_ovf got r=%h s=%b o=%b i=%b want r=000 s=0 o=1 i=0", r, s, v, iv); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL add_ovf_latency got %0d want 5", lat); end
  endtask

  task automatic test_sub_direct();
    int lat; logic [11:0] r; logic s, v, iv, b1, d2;
    do_op(1'b1, 1'b0, 12'h250, 1'b0, 12'h100, lat, r, s, v, iv, b1, d2);
    checks++; if (lat !== 5) begin failures++; $display("FAIL sub_latency got %0d want 5", lat); end
    checks++; if ({r, s, v} !== {12'h150, 2'b00}) begin failures++; $display("FAIL sub_250_100 got r=%h s=%b o=%b want r=150 s=0 o=0", r, s, v); end
    do_op(1'b0, 1'b1, 12'h250, 1'b0, 12'h100, lat, r, s, v, iv, b1, d2);
    checks++; if ({r, s, v} !== {12'h150, 2'b10}) begin failures++; $display("FAIL neg250_plus100 got r=%h s=%b o=%b want r=150 s=1 o=0", r, s, v); end
  endtask

  task automatic test_sub_complement();
    int lat; logic [11:0] r; logic s, v, iv, b1, d2;
    do_op(1'b1, 1'b0, 12'h100, 1'b0, 12'h250, lat, r, s, v, iv, b1, d2);
    checks++; if (lat !== 8) begin failures++; $display("FAIL comp_latency got %0d want 8", lat); end
    checks++; if ({r, s, v} !== {12'h150, 2'b10}) begin failures++; $display("FAIL sub_100_250 got r=%h s=%b o=%b want r=150 s=1 o=0", r, s, v); end
    checks++; if (d2 !== 1'b0) begin failures++; $display("FAIL comp_done_pulse got %b want 0", d2); end
    do_op(1'b0, 1'b1, 12'h300, 1'b0, 12'h300, lat, r, s, v, iv, b1, d2);
    checks++; if ({r, s, v} !== {12'h000, 2'b00}) begin failures++; $display("FAIL neg_zero got r=%h s=%b o=%b want r=000 s=0 o=0", r, s, v); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL neg_zero_latency got %0d want 5", lat); end
  endtask

  task automatic test_start_ignored();
    int lat;
    op = 1'b0; sign_a = 1'b0; a_bcd = 12'h123; sign_b = 1'b0; b_bcd = 12'h456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; a_bcd = 12'h999; b_bcd = 12'h999;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    checks++; if (lat !== 5) begin failures++; $display("FAIL ignore_latency got %0d want 5", lat); end
    checks++; if ({r_bcd, sign_r, ovf} !== {12'h579, 2'b00}) begin failures++; $display("FAIL ignore_result got r=%h s=%b o=%b want r=579 s=0 o=0", r_bcd, sign_r, ovf); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL done_start_idle got busy/done=%b want 00", {busy, done}); end
    @(posedge clk); #1;
    checks++; if ({busy, done, r_bcd} !== {2'b00, 12'h579}) begin failures++; $display("FAIL done_start_ignored got busy/done/r=%b/%h want 00/579", {busy, done}, r_bcd); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    op = 1'b1; sign_a = 1'b0; a_bcd = 12'h100; sign_b = 1'b0; b_bcd = 12'h250; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, r_bcd, sign_r, ovf, invalid} !== 17'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got %h want 0", {busy, done, r_bcd, sign_r, ovf, invalid});
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL mid_no_done got %b want 0", saw_done); end
  endtask

  task automatic test_start_after_reset();
    int lat; logic [11:0] r; logic s, v, iv, b1, d2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, lat, r, s, v, iv, b1, d2);
    checks++; if (lat !== 5) begin failures++; $display("FAIL post_reset_latency got %0d want 5", lat); end
    checks++; if ({r, s, v, iv} !== {12'h579, 3'b000}) begin failures++; $display("FAIL post_reset_result got r=%h s=%b o=%b i=%b want 579/0/0/0", r, s, v, iv); end
  endtask

  task automatic test_invalid();
    int lat; logic [11:0] r; logic s, v, iv, b1, d2;
    do_op(1'b0, 1'b0, 12'h1A0, 1'b0, 12'h000, lat, r, s, v, iv, b1, d2);
    checks++; if (iv !== 1'b1) begin failures++; $display("FAIL invalid_flag got %b want 1", iv); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL invalid_latency got %0d want 5", lat); end
    do_op(1'b0, 1'b0, 12'h001, 1'b0, 12'h002, lat, r, s, v, iv, b1, d2);
    checks++; if ({r, iv} !== {12'h003, 1'b0}) begin failures++; $display("FAIL invalid_clears got r=%h i=%b want 003/0", r, iv); end
  endtask

  initial begin
    #3;
    test_reset();
    test_add();
    test_sub_direct();
    test_sub_complement();
    test_start_ignored();
    test_reset_mid();
    test_start_after_reset();
    test_invalid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd3_signed_addsub_seq.md
BCD3_SIGNED_ADDSUB_SEQ -- requirements
Module: bcd3_signed_addsub_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all other ports are listed below.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = A+B, 1 = A-B.
REQ-006 sign_a, sign_b  input  1 each  operand signs (1 = negative); signed-magnitude.
REQ-007 a_bcd, b_bcd  input  12 each  3-digit BCD magnitudes, [3:0] = units digit.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 r_bcd  output  12  3-digit BCD result magnitude.
REQ-011 sign_r  output  1  result sign.
REQ-012 ovf  output  1  magnitude exceeded 999.
REQ-013 invalid  output  1  a captured input digit was >9; r_bcd, sign_r and ovf are then don't-care.

Function
REQ-014 On start in IDLE, the block SHALL capture all operands and op, and compute eff_sub = op ^ sign_a ^ sign_b.
REQ-015 FSM states: IDLE -> ADD0 -> ADD1 -> ADD2 -> CHK -> (COMP0 -> COMP1 -> COMP2 ->) DONE -> IDLE.
REQ-016 A single-digit BCD adder (a, b, cin -> sum, cout) SHALL be time-shared, with one digit per cycle, units first, and carry registered between digits.
REQ-017 ADDk: a = A digit k; b = B digit k if eff_sub=0, else 9 - B digit k; cin for ADD0 = eff_sub.
REQ-018 CHK, eff_sub=0: ovf = final carry, sign_r = sign_a, then go to DONE.
REQ-019 CHK, eff_sub=1, final carry=1: ovf = 0, sign_r = sign_a, then go to DONE.
REQ-020 CHK, eff_sub=1, final carry=0: go to COMP0; sign_r = ~sign_a.
REQ-021 COMPk: a = 9 - partial digit k, b = 0, cin for COMP0 = 1 (10's complement), written back in place.
REQ-022 A zero result magnitude SHALL force sign_r = 0 (no negative zero).
REQ-023 Latency from the start-sample edge to done high SHALL be 5 cycles without the complement pass and 8 cycles with it.
REQ-024 done SHALL be high only in DONE; busy SHALL be high in ADD0..COMP2 and low in IDLE and DONE.
REQ-025 r_bcd, sign_r, ovf and invalid SHALL update only on entry to DONE and hold until the next DONE.
REQ-026 start while not in IDLE (including DONE) SHALL be ignored with no side effects.
REQ-027 Input digits >9 SHALL set invalid at DONE; the sequence length is unchanged.

Reset
REQ-028 rst SHALL asynchronously force IDLE and set busy, done, r_bcd, sign_r, ovf, invalid, carry and all operand registers to 0.
REQ-029 Reset mid-operation SHALL abandon the computation with no done pulse; a start on the first cycle after deassertion SHALL be accepted.

Structure
REQ-030 A shared package SHALL hold the state encodings, NDIG = 3, and BCD_NINE = 4'd9.
REQ-031 The single-digit BCD adder SHALL be one sub-module, bcd_digit_adder: combinational, with a +6 correction when the sum exceeds 9 or the binary carry is set.
REQ-032 It SHALL be instantiated exactly once; the FSM muxes its inputs.

Verification
REQ-033 +123 + +456 (op=0) -> r_bcd=579, sign_r=0, ovf=0, done 5 cycles after start.
REQ-034 +999 + +001 -> r_bcd=000, ovf=1, sign_r=0.
REQ-035 +250 - +100 (op=1) -> r_bcd=150, sign_r=0, 5-cycle latency; -250 + +100 -> r_bcd=150, sign_r=1.
REQ-036 +100 - +250 -> r_bcd=250-100=150, sign_r=1, done 8 cycles after start; -300 + +300 -> r_bcd=000, sign_r=0.
REQ-037 Start in ADD1 -> ignored, first result unaffected; rst pulse in COMP1 -> all outputs 0 immediately, no done; a following start completes normally.
REQ-038 a_bcd=0x1A0 -> invalid=1 at done, latency 5 cycles.
